// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: shares the CSR write port between instruction CSR writes and M-mode trap entry / MRET
// Ports: trap_req/trap_ack and mret_req/mret_ack handshakes (trap fields sampled on ack), insn_csr_* instruction
// write path with a combinational grant, mstatus_in/mtvec_in/mepc_in current CSR values, csr_we/csr_waddr/csr_wdata
// shared write port, redirect_valid/redirect_pc PC redirect strobe, busy while a sequence is in flight.
module csr_trap_sequencer #(
    parameter int XLEN        = 32,
    parameter int ALEN        = 12,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic [XLEN-1:0] trap_pc,
    output logic            trap_ack,
    input  logic            mret_req,
    output logic            mret_ack,
    input  logic            insn_csr_req,
    input  logic [ALEN-1:0] insn_csr_addr,
    input  logic [XLEN-1:0] insn_csr_wdata,
    output logic            insn_csr_gnt,
    input  logic [XLEN-1:0] mstatus_in,
    input  logic [XLEN-1:0] mtvec_in,
    input  logic [XLEN-1:0] mepc_in,
    output logic            csr_we,
    output logic [ALEN-1:0] csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);
    typedef enum logic [2:0] {IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, M_MSTATUS, REDIRECT} state_t;
    state_t state;
    logic [XLEN-1:0] cause, tval, mstatus, mtvec, wdata, rpc;
    logic [XLEN-1:0] base, target, trap_status, mret_status;
    logic [ALEN-1:0] waddr;
    logic we, rv, idle;

    // Reset also masks every output in the cycle it is asserted, so an abort takes effect immediately.
    assign idle = state == IDLE && !rst;
    assign trap_ack = idle && trap_req;
    assign mret_ack = idle && !trap_req && mret_req;
    assign insn_csr_gnt = idle && !trap_req && !mret_req && insn_csr_req;
    assign busy = state != IDLE && !rst;
    assign csr_we = !rst && (we || insn_csr_gnt);
    assign csr_waddr = !csr_we ? '0 : we ? waddr : insn_csr_addr;
    assign csr_wdata = !csr_we ? '0 : we ? wdata : insn_csr_wdata;
    assign redirect_valid = rv && !rst;
    assign redirect_pc = redirect_valid ? rpc : '0;

    // Vector offset wraps modulo 2^XLEN; the interrupt flag is shifted out.
    assign base = mtvec & ~XLEN'(3);
    assign target = (VECTORED_EN && mtvec[1:0] == 2'b01 && cause[XLEN-1]) ? base + (cause << 2) : base;

    always_comb begin
        trap_status = mstatus;
        trap_status[7] = mstatus[3];
        trap_status[3] = 1'b0;
        trap_status[12:11] = 2'b11;
    end

    always_comb begin
        mret_status = mstatus_in;
        mret_status[3] = mstatus_in[7];
        mret_status[7] = 1'b1;
        mret_status[12:11] = 2'b11;
    end

    // Write-port values are registered one state ahead so each state presents its own write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cause <= '0;
            tval <= '0;
            mstatus <= '0;
            mtvec <= '0;
            we <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            rv <= 1'b0;
            rpc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_req) begin
                        state <= T_MEPC;
                        cause <= trap_cause;
                        tval <= trap_tval;
                        mstatus <= mstatus_in;
                        mtvec <= mtvec_in;
                        we <= 1'b1;
                        waddr <= ALEN'(12'h341);
                        wdata <= trap_pc & ~XLEN'(3);
                    end else if (mret_req) begin
                        state <= M_MSTATUS;
                        we <= 1'b1;
                        waddr <= ALEN'(12'h300);
                        wdata <= mret_status;
                        rpc <= mepc_in & ~XLEN'(3);
                    end
                end
                T_MEPC: begin
                    state <= T_MCAUSE;
                    waddr <= ALEN'(12'h342);
                    wdata <= cause;
                end
                T_MCAUSE: begin
                    state <= T_MTVAL;
                    waddr <= ALEN'(12'h343);
                    wdata <= tval;
                end
                T_MTVAL: begin
                    state <= T_MSTATUS;
                    waddr <= ALEN'(12'h300);
                    wdata <= trap_status;
                end
                T_MSTATUS: begin
                    state <= REDIRECT;
                    we <= 1'b0;
                    waddr <= '0;
                    wdata <= '0;
                    rv <= 1'b1;
                    rpc <= target;
                end
                M_MSTATUS: begin
                    state <= REDIRECT;
                    we <= 1'b0;
                    waddr <= '0;
                    wdata <= '0;
                    rv <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    rv <= 1'b0;
                    rpc <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb_csr_trap_sequencer: scoreboard bench for csr_trap_sequencer with a cycle-level reference model
module tb_csr_trap_sequencer;
    typedef struct {int cyc; logic [11:0] a; logic [31:0] d;} ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, trap_req, mret_req, insn_csr_req;
    logic [31:0] trap_cause, trap_tval, trap_pc, insn_csr_wdata, mstatus_in, mtvec_in, mepc_in;
    logic [11:0] insn_csr_addr;
    logic trap_ack, mret_ack, insn_csr_gnt, csr_we, redirect_valid, busy;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, redirect_pc;
    logic v0_trap_ack, v0_mret_ack, v0_gnt, v0_we, v0_rv, v0_busy;
    logic [11:0] v0_waddr;
    logic [31:0] v0_wdata, v0_rpc;

    logic n_rst, n_trap_req, n_mret_req, n_insn_req;
    logic [31:0] n_cause, n_tval, n_pc, n_idata, n_mstatus, n_mtvec, n_mepc;
    logic [11:0] n_iaddr;

    int cyc = 0, free_at = 0, acc = -1, checks = 0, failures = 0;
    logic e_busy = 1'b0;
    ev_t q_wr[$], q_rd[$], q_rd0[$], q_ack[$];
    ev_t log_wr[$], log_rd[$], log_rd0[$], log_ack[$];

    csr_trap_sequencer #(.XLEN(32), .ALEN(12), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .trap_req(trap_req), .trap_cause(trap_cause), .trap_tval(trap_tval),
        .trap_pc(trap_pc), .trap_ack(trap_ack), .mret_req(mret_req), .mret_ack(mret_ack),
        .insn_csr_req(insn_csr_req), .insn_csr_addr(insn_csr_addr), .insn_csr_wdata(insn_csr_wdata),
        .insn_csr_gnt(insn_csr_gnt), .mstatus_in(mstatus_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy));

    csr_trap_sequencer #(.XLEN(32), .ALEN(12), .VECTORED_EN(1'b0)) u0 (
        .clk(clk), .rst(rst), .trap_req(trap_req), .trap_cause(trap_cause), .trap_tval(trap_tval),
        .trap_pc(trap_pc), .trap_ack(v0_trap_ack), .mret_req(mret_req), .mret_ack(v0_mret_ack),
        .insn_csr_req(insn_csr_req), .insn_csr_addr(insn_csr_addr), .insn_csr_wdata(insn_csr_wdata),
        .insn_csr_gnt(v0_gnt), .mstatus_in(mstatus_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
        .csr_we(v0_we), .csr_waddr(v0_waddr), .csr_wdata(v0_wdata), .redirect_valid(v0_rv),
        .redirect_pc(v0_rpc), .busy(v0_busy));

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, exp);
        end
    endtask

    task automatic bad(input string n, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d got=%h want=none", n, cyc, act);
    endtask

    // Reference model: trap = ack now, four writes on the next four cycles, redirect one later, free after that.
    task automatic model();
        logic [31:0] s, base, tgt;
        e_busy = 1'b0;
        if (rst) begin
            while (q_wr.size() != 0 && q_wr[$].cyc >= cyc) void'(q_wr.pop_back());
            while (q_rd.size() != 0 && q_rd[$].cyc >= cyc) void'(q_rd.pop_back());
            while (q_rd0.size() != 0 && q_rd0[$].cyc >= cyc) void'(q_rd0.pop_back());
            while (q_ack.size() != 0 && q_ack[$].cyc >= cyc) void'(q_ack.pop_back());
            free_at = cyc + 1;
            acc = cyc;
            return;
        end
        e_busy = cyc > acc && cyc < free_at;
        if (cyc < free_at) return;
        if (trap_req) begin
            s = mstatus_in;
            base = mtvec_in & ~32'd3;
            tgt = (mtvec_in[1:0] == 2'b01 && trap_cause[31]) ? base + trap_cause * 4 : base;
            q_ack.push_back('{cyc, 12'd0, 32'd0});
            q_wr.push_back('{cyc + 1, 12'h341, trap_pc & ~32'd3});
            q_wr.push_back('{cyc + 2, 12'h342, trap_cause});
            q_wr.push_back('{cyc + 3, 12'h343, trap_tval});
            q_wr.push_back('{cyc + 4, 12'h300, (s & ~32'h88) | ((s & 32'h8) << 4) | 32'h1800});
            q_rd.push_back('{cyc + 5, 12'd0, tgt});
            q_rd0.push_back('{cyc + 5, 12'd0, base});
            acc = cyc;
            free_at = cyc + 6;
            n_trap_req = 1'b0;
        end else if (mret_req) begin
            s = mstatus_in;
            q_ack.push_back('{cyc, 12'd1, 32'd0});
            q_wr.push_back('{cyc + 1, 12'h300, (s & ~32'h8) | ((s >> 4) & 32'h8) | 32'h1880});
            q_rd.push_back('{cyc + 2, 12'd0, mepc_in & ~32'd3});
            q_rd0.push_back('{cyc + 2, 12'd0, mepc_in & ~32'd3});
            acc = cyc;
            free_at = cyc + 3;
            n_mret_req = 1'b0;
        end else if (insn_csr_req) begin
            q_ack.push_back('{cyc, 12'd2, 32'd0});
            q_wr.push_back('{cyc, insn_csr_addr, insn_csr_wdata});
            n_insn_req = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst = n_rst;
        trap_req = n_trap_req;
        trap_cause = n_cause;
        trap_tval = n_tval;
        trap_pc = n_pc;
        mret_req = n_mret_req;
        insn_csr_req = n_insn_req;
        insn_csr_addr = n_iaddr;
        insn_csr_wdata = n_idata;
        mstatus_in = n_mstatus;
        mtvec_in = n_mtvec;
        mepc_in = n_mepc;
        model();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_logs();
        log_wr.delete();
        log_rd.delete();
        log_rd0.delete();
        log_ack.delete();
    endtask

    task automatic exp_wr(input int i, input int c, input logic [11:0] a, input logic [31:0] d);
        if (i >= log_wr.size()) bad("log_wr_missing", 64'(i));
        else begin
            chk("log_wr_cyc", 64'(log_wr[i].cyc), 64'(c));
            chk("log_wr_addr", 64'(log_wr[i].a), 64'(a));
            chk("log_wr_data", 64'(log_wr[i].d), 64'(d));
        end
    endtask

    task automatic exp_rd(input int c, input logic [31:0] pc, input logic [31:0] pc0);
        if (log_rd.size() != 1 || log_rd0.size() != 1) bad("log_rd_count", 64'(log_rd.size()));
        else begin
            chk("log_rd_cyc", 64'(log_rd[0].cyc), 64'(c));
            chk("log_rd_pc", 64'(log_rd[0].d), 64'(pc));
            chk("log_rd0_pc", 64'(log_rd0[0].d), 64'(pc0));
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        int n;
        chk("busy", 64'(busy), 64'(e_busy));
        if (csr_we) begin
            log_wr.push_back('{cyc, csr_waddr, csr_wdata});
            if (q_wr.size() == 0) bad("wr_unexpected", {20'd0, csr_waddr, csr_wdata});
            else begin
                e = q_wr.pop_front();
                chk("wr_cyc", 64'(cyc), 64'(e.cyc));
                chk("wr_addr", 64'(csr_waddr), 64'(e.a));
                chk("wr_data", 64'(csr_wdata), 64'(e.d));
            end
        end else chk("wr_idle_zero", {20'd0, csr_waddr, csr_wdata}, 64'd0);
        if (redirect_valid) begin
            log_rd.push_back('{cyc, 12'd0, redirect_pc});
            if (q_rd.size() == 0) bad("rd_unexpected", 64'(redirect_pc));
            else begin
                e = q_rd.pop_front();
                chk("rd_cyc", 64'(cyc), 64'(e.cyc));
                chk("rd_pc", 64'(redirect_pc), 64'(e.d));
            end
        end
        if (v0_rv) begin
            log_rd0.push_back('{cyc, 12'd0, v0_rpc});
            if (q_rd0.size() == 0) bad("rd0_unexpected", 64'(v0_rpc));
            else begin
                e = q_rd0.pop_front();
                chk("rd0_cyc", 64'(cyc), 64'(e.cyc));
                chk("rd0_pc", 64'(v0_rpc), 64'(e.d));
            end
        end
        n = int'(trap_ack) + int'(mret_ack) + int'(insn_csr_gnt);
        if (n > 1) bad("ack_multi", {61'd0, trap_ack, mret_ack, insn_csr_gnt});
        else if (n == 1) begin
            log_ack.push_back('{cyc, trap_ack ? 12'd0 : mret_ack ? 12'd1 : 12'd2, 32'd0});
            if (q_ack.size() == 0) bad("ack_unexpected", 64'(log_ack[$].a));
            else begin
                e = q_ack.pop_front();
                chk("ack_cyc", 64'(cyc), 64'(e.cyc));
                chk("ack_kind", 64'(log_ack[$].a), 64'(e.a));
            end
        end
    end

    initial begin
        int t0;
        n_rst = 1'b1;
        {n_trap_req, n_mret_req, n_insn_req} = '0;
        {n_cause, n_tval, n_pc, n_idata, n_mstatus, n_mtvec, n_mepc} = '0;
        n_iaddr = '0;
        steps(3);
        n_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            #1;
            chk("idle_ctl", 64'({trap_ack, mret_ack, insn_csr_gnt, csr_we, redirect_valid, busy}), 64'd0);
            chk("idle_bus", {20'd0, csr_waddr, csr_wdata}, 64'd0);
            chk("idle_rpc", 64'(redirect_pc), 64'd0);
        end

        n_mstatus = 32'h8; n_pc = 32'h1006; n_cause = 32'h2; n_tval = 32'hDEADBEEF; n_mtvec = 32'h100;
        n_trap_req = 1'b1;
        clear_logs();
        step();
        t0 = cyc;
        steps(8);
        exp_wr(0, t0 + 1, 12'h341, 32'h1004);
        exp_wr(1, t0 + 2, 12'h342, 32'h2);
        exp_wr(2, t0 + 3, 12'h343, 32'hDEADBEEF);
        exp_wr(3, t0 + 4, 12'h300, 32'h1880);
        exp_rd(t0 + 5, 32'h100, 32'h100);

        n_mtvec = 32'h201; n_cause = 32'h80000007; n_trap_req = 1'b1;
        clear_logs();
        step();
        t0 = cyc;
        steps(8);
        exp_rd(t0 + 5, 32'h21C, 32'h200);

        n_mstatus = 32'h1880; n_mepc = 32'h1004; n_mret_req = 1'b1;
        clear_logs();
        step();
        t0 = cyc;
        steps(4);
        exp_wr(0, t0 + 1, 12'h300, 32'h1888);
        exp_rd(t0 + 2, 32'h1004, 32'h1004);

        n_trap_req = 1'b1; n_mret_req = 1'b1; n_insn_req = 1'b1; n_iaddr = 12'h305; n_idata = 32'h55AA;
        clear_logs();
        step();
        t0 = cyc;
        steps(12);
        if (log_ack.size() != 3) bad("contention_acks", 64'(log_ack.size()));
        else begin
            chk("cont_trap_cyc", 64'(log_ack[0].cyc), 64'(t0));
            chk("cont_trap_kind", 64'(log_ack[0].a), 64'd0);
            chk("cont_mret_cyc", 64'(log_ack[1].cyc), 64'(t0 + 6));
            chk("cont_mret_kind", 64'(log_ack[1].a), 64'd1);
            chk("cont_gnt_cyc", 64'(log_ack[2].cyc), 64'(t0 + 9));
            chk("cont_gnt_kind", 64'(log_ack[2].a), 64'd2);
        end

        n_trap_req = 1'b1;
        step();
        step();
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
        clear_logs();
        step();
        @(negedge clk);
        #1;
        chk("abort_we", 64'(csr_we), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        steps(8);
        chk("abort_writes", 64'(log_wr.size()), 64'd0);
        chk("abort_redirect", 64'(log_rd.size()), 64'd0);

        for (int i = 0; i < 1500; i++) begin
            n_mstatus = $urandom; n_mtvec = $urandom; n_mepc = $urandom;
            n_rst = $urandom_range(0, 99) == 0;
            if (!n_trap_req && $urandom_range(0, 7) == 0) begin
                n_trap_req = 1'b1;
                n_cause = $urandom; n_tval = $urandom; n_pc = $urandom;
            end
            if (!n_mret_req && $urandom_range(0, 7) == 0) n_mret_req = 1'b1;
            if (!n_insn_req && $urandom_range(0, 2) == 0) begin
                n_insn_req = 1'b1;
                n_iaddr = 12'($urandom); n_idata = $urandom;
            end
            step();
        end
        n_rst = 1'b0;
        steps(40);
        chk("q_wr_left", 64'(q_wr.size()), 64'd0);
        chk("q_rd_left", 64'(q_rd.size()), 64'd0);
        chk("q_rd0_left", 64'(q_rd0.size()), 64'd0);
        chk("q_ack_left", 64'(q_ack.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
